// File: rtl/controller_snes_multi_pkg.sv
// Shared types, bit-order constants and timing helper for the SNES/NES pad scanner.
// Imported by the interface, the shift channel and controller_snes_multi.
package controller_pkg;

    typedef enum logic [1:0] {
        LATCH    = 2'd0,
        CLK_HIGH = 2'd1,
        CLK_LOW  = 2'd2,
        WAIT     = 2'd3
    } ctrl_state_e;

    // SNES pad: position in the serial stream == index in buttons
    localparam int unsigned SNES_B      = 0;
    localparam int unsigned SNES_Y      = 1;
    localparam int unsigned SNES_SELECT = 2;
    localparam int unsigned SNES_START  = 3;
    localparam int unsigned SNES_UP     = 4;
    localparam int unsigned SNES_DOWN   = 5;
    localparam int unsigned SNES_LEFT   = 6;
    localparam int unsigned SNES_RIGHT  = 7;
    localparam int unsigned SNES_A      = 8;
    localparam int unsigned SNES_X      = 9;
    localparam int unsigned SNES_L      = 10;
    localparam int unsigned SNES_R      = 11;

    localparam int unsigned NES_A      = 0;
    localparam int unsigned NES_B      = 1;
    localparam int unsigned NES_SELECT = 2;
    localparam int unsigned NES_START  = 3;
    localparam int unsigned NES_UP     = 4;
    localparam int unsigned NES_DOWN   = 5;
    localparam int unsigned NES_LEFT   = 6;
    localparam int unsigned NES_RIGHT  = 7;

    function automatic int unsigned us_to_cycles(
        input int unsigned freq,
        input int unsigned us
    );
        return freq / 1_000_000 * us;
    endfunction

endpackage

// File: rtl/controller_snes_multi_if.sv
// Pad-side and core-side signals of controller_snes_multi.
// scan_req exists only when CONTROLLER_SCAN_TRIGGER_EN is defined.
interface controller_snes_multi_if #(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned NBITS  = 16
);
    logic                     joy_strb;
    logic                     joy_clk;
    logic [NPORTS-1:0]        joy_data;
    logic [NPORTS*NBITS-1:0]  buttons;
    logic                     valid;
    logic                     changed;
`ifdef CONTROLLER_SCAN_TRIGGER_EN
    logic                     scan_req;

    modport master (
        output joy_strb, joy_clk, buttons, valid, changed,
        input  joy_data, scan_req
    );

    modport slave (
        input  joy_strb, joy_clk, buttons, valid, changed,
        output joy_data, scan_req
    );
`else
    modport master (
        output joy_strb, joy_clk, buttons, valid, changed,
        input  joy_data
    );

    modport slave (
        input  joy_strb, joy_clk, buttons, valid, changed,
        output joy_data
    );
`endif
endinterface

// File: rtl/controller_snes_multi_shift_chan.sv
// One pad data line: 2-flop synchroniser and an LSB-first shift register.
// The line is active-low; the register holds 1 for pressed.
module controller_shift_chan #(
    parameter int unsigned NBITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             shift_en,
    output logic [NBITS-1:0] sr
);

    logic [1:0]       sync_q;
    logic [1:0]       sync_d;
    logic [NBITS-1:0] sr_q;
    logic [NBITS-1:0] sr_d;

    always_comb begin
        sync_d = {sync_q[0], data_in};
        sr_d   = sr_q;
        if (shift_en) begin
            sr_d = {~sync_q[1], sr_q[NBITS-1:1]};
        end
    end

    // Synchroniser resets to the released (pulled-up) level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            sr_q   <= '0;
        end else begin
            sync_q <= sync_d;
            sr_q   <= sr_d;
        end
    end

    assign sr = sr_q;

endmodule

// File: rtl/controller_snes_multi.sv
// Self-scanning serial pad interface: NPORTS pads share one latch and one clock.
// Define CONTROLLER_SCAN_TRIGGER_EN to scan on scan_req instead of free-running.
module controller_snes_multi
    import controller_pkg::*;
#(
    parameter int unsigned FREQ      = 21_500_000,
    parameter int unsigned NPORTS    = 2,
    parameter int unsigned NBITS     = 16,
    parameter int unsigned HALF_US   = 6,
    parameter int unsigned PERIOD_US = 16000
) (
    input  logic                    clk,
    input  logic                    reset,
    controller_snes_multi_if.master bus
);

    localparam int unsigned T_HALF = us_to_cycles(FREQ, HALF_US);
    localparam int unsigned T_SCAN = 2 * T_HALF * (NBITS + 1);
    localparam int unsigned BW     = $clog2(NBITS + 1);

`ifdef CONTROLLER_SCAN_TRIGGER_EN
    localparam int unsigned CW = $clog2(2 * T_HALF);
    localparam ctrl_state_e RESET_STATE = WAIT;
`else
    localparam int unsigned T_PER  = us_to_cycles(FREQ, PERIOD_US);
    localparam int unsigned T_WAIT = T_PER - T_SCAN;
    localparam int unsigned CW     = $clog2(T_PER);
    localparam ctrl_state_e RESET_STATE = LATCH;

    if (T_PER <= T_SCAN) begin : g_bad_period
        $error("scan period shorter than one scan");
    end
`endif

    if (T_HALF < 4) begin : g_bad_half
        $error("T_HALF must be at least 4 cycles");
    end

    if (NPORTS < 1 || NPORTS > 4) begin : g_bad_ports
        $error("NPORTS must be 1..4");
    end

    if (NBITS < 2) begin : g_bad_bits
        $error("NBITS must be at least 2");
    end

    ctrl_state_e             state_q;
    ctrl_state_e             state_d;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;
    logic [BW-1:0]           bit_q;
    logic [BW-1:0]           bit_d;
    logic                    joy_strb_q;
    logic                    joy_strb_d;
    logic                    joy_clk_q;
    logic                    joy_clk_d;
    logic [NPORTS*NBITS-1:0] buttons_q;
    logic [NPORTS*NBITS-1:0] buttons_d;
    logic                    valid_q;
    logic                    valid_d;
    logic                    changed_q;
    logic                    changed_d;
    logic                    shift_en;
    logic [NPORTS*NBITS-1:0] sr_all;

    for (genvar p = 0; p < NPORTS; p++) begin : g_chan
        controller_shift_chan #(
            .NBITS(NBITS)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .data_in (bus.joy_data[p]),
            .shift_en(shift_en),
            .sr      (sr_all[p*NBITS +: NBITS])
        );
    end

    // Pad outputs are registered copies of the state, so the
    // latch and clock edges always land on different cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        joy_strb_d = 1'b0;
        joy_clk_d  = 1'b1;
        shift_en   = 1'b0;
        buttons_d  = buttons_q;
        valid_d    = 1'b0;
        changed_d  = 1'b0;

        unique case (state_q)
            LATCH: begin
                joy_strb_d = 1'b1;
                if (cnt_q == CW'(2 * T_HALF - 1)) begin
                    state_d = CLK_HIGH;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end

            CLK_HIGH: begin
                if (cnt_q == CW'(T_HALF - 1)) begin
                    joy_clk_d = 1'b0;
                    shift_en  = 1'b1;
                    state_d   = CLK_LOW;
                    cnt_d     = '0;
                end
            end

            CLK_LOW: begin
                joy_clk_d = 1'b0;
                if (cnt_q == CW'(T_HALF - 1)) begin
                    joy_clk_d = 1'b1;
                    cnt_d     = '0;
                    bit_d     = bit_q + 1'b1;
                    if (bit_q == BW'(NBITS - 1)) begin
                        buttons_d = sr_all;
                        valid_d   = 1'b1;
                        changed_d = (sr_all != buttons_q);
                        state_d   = WAIT;
                    end else begin
                        state_d = CLK_HIGH;
                    end
                end
            end

            WAIT: begin
`ifdef CONTROLLER_SCAN_TRIGGER_EN
                cnt_d = '0;
                if (bus.scan_req) begin
                    state_d = LATCH;
                end
`else
                if (cnt_q == CW'(T_WAIT - 1)) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end
`endif
            end

            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            bit_q      <= '0;
            joy_strb_q <= 1'b0;
            joy_clk_q  <= 1'b1;
            buttons_q  <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            joy_strb_q <= joy_strb_d;
            joy_clk_q  <= joy_clk_d;
            buttons_q  <= buttons_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
        end
    end

    assign bus.joy_strb = joy_strb_q;
    assign bus.joy_clk  = joy_clk_q;
    assign bus.buttons  = buttons_q;
    assign bus.valid    = valid_q;
    assign bus.changed  = changed_q;

endmodule

// File: tb/tb_controller_snes_multi.sv
// Bench for controller_snes_multi: pad models, edge-timing monitor, vector table
// and randomized scans; trigger-mode sequence when CONTROLLER_SCAN_TRIGGER_EN is set.
module tb_controller_snes_multi;
    import controller_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    controller_snes_multi_if #(.NPORTS(2), .NBITS(16)) ifa ();
    controller_snes_multi_if #(.NPORTS(1), .NBITS(8))  ifb ();

    controller_snes_multi #(
        .FREQ(2_000_000), .NPORTS(2), .NBITS(16),
        .HALF_US(6), .PERIOD_US(1000)
    ) dut_a (
        .clk  (clk),
        .reset(rst_a),
        .bus  (ifa)
    );

    controller_snes_multi #(
        .FREQ(2_000_000), .NPORTS(1), .NBITS(8),
        .HALF_US(6), .PERIOD_US(500)
    ) dut_b (
        .clk  (clk),
        .reset(rst_b),
        .bus  (ifb)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pad model: a pad latches its pressed set while strobed, then presents
    // one button per joy_clk rising edge, active low, idle high afterwards.
    function automatic logic pad_out(input logic [15:0] pat, input int idx,
                                     input int nb);
        logic [15:0] s;
        if (idx < 0 || idx >= nb) return 1'b1;
        s = pat >> idx;
        return ~s[0];
    endfunction

    logic [15:0] pat_a [2];
    logic [15:0] lat_a [2];
    int          idx_a   = 99;
    int          nfall_a = 0;
    logic        pclk_a  = 1'b1;

    always @(negedge clk) begin
        if (ifa.joy_strb) begin
            idx_a   = 0;
            nfall_a = 0;
            lat_a   = pat_a;
        end else begin
            if (ifa.joy_clk && !pclk_a) idx_a++;
            if (!ifa.joy_clk && pclk_a) nfall_a++;
        end
        pclk_a = ifa.joy_clk;
    end

    assign ifa.joy_data[0] = pad_out(lat_a[0], idx_a, 16);
    assign ifa.joy_data[1] = pad_out(lat_a[1], idx_a, 16);

    logic [7:0] pat_b;
    logic [7:0] lat_b;
    int         idx_b   = 99;
    int         nfall_b = 0;
    logic       pclk_b  = 1'b1;

    always @(negedge clk) begin
        if (ifb.joy_strb) begin
            idx_b   = 0;
            nfall_b = 0;
            lat_b   = pat_b;
        end else begin
            if (ifb.joy_clk && !pclk_b) idx_b++;
            if (!ifb.joy_clk && pclk_b) nfall_b++;
        end
        pclk_b = ifb.joy_clk;
    end

    assign ifb.joy_data[0] = pad_out({8'h00, lat_b}, idx_b, 8);

`ifdef CONTROLLER_SCAN_TRIGGER_EN
    assign ifb.scan_req = 1'b0;
`endif

    // Edge-timing monitor for DUT A (T_HALF = 12, T_PER = 2000)
    bit   mon_a  = 0;
    logic ps_a   = 1'b0;
    logic pc_a   = 1'b1;
    int   rise_t = -1;
    int   fall_t = 0;
    int   crise_t = 0;
    int   nlow   = 0;

    always @(negedge clk) begin
        if (rst_a) begin
            rise_t = -1;
            nlow   = 0;
        end else if (mon_a) begin
            if (ifa.joy_strb != ps_a)
                chk("strb_clk_same_cycle", 64'(ifa.joy_clk != pc_a), 0);
            if (ifa.joy_strb && !ps_a) begin
                if (rise_t >= 0)
                    chk("latch_period", 64'(cyc - rise_t), 2000);
                rise_t = cyc;
                nlow   = 0;
            end
            if (!ifa.joy_strb && ps_a && rise_t >= 0)
                chk("strb_width", 64'(cyc - rise_t), 24);
            if (!ifa.joy_clk && pc_a) begin
                if (nlow > 0)
                    chk("clk_high_gap", 64'(cyc - crise_t), 12);
                fall_t = cyc;
            end
            if (ifa.joy_clk && !pc_a) begin
                chk("clk_low_width", 64'(cyc - fall_t), 12);
                nlow++;
                crise_t = cyc;
            end
        end
        ps_a = ifa.joy_strb;
        pc_a = ifa.joy_clk;
    end

    task automatic wait_valid_a(output bit ok);
        ok = 0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (ifa.valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("valid_a_timeout", 64'(ifa.valid), 1);
    endtask

    task automatic wait_valid_b(output bit ok);
        ok = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (ifb.valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("valid_b_timeout", 64'(ifb.valid), 1);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_strb"}, 64'(ifa.joy_strb), 0);
        chk({tag, "_clk"}, 64'(ifa.joy_clk), 1);
        chk({tag, "_buttons"}, 64'(ifa.buttons), 0);
        chk({tag, "_valid"}, 64'(ifa.valid), 0);
        chk({tag, "_changed"}, 64'(ifa.changed), 0);
    endtask

    typedef struct {
        logic [15:0] p0;
        logic [15:0] p1;
        logic [31:0] btn;
        logic        chg;
    } vec_t;

    task automatic run_a();
        vec_t        vt [5];
        bit          ok;
        logic [31:0] prev;
        logic [31:0] expv;
        logic [15:0] p0;
        logic [15:0] p1;

        vt[0] = '{p0: 16'h0101, p1: 16'h0000, btn: 32'h0000_0101, chg: 1'b1};
        vt[1] = '{p0: 16'h0101, p1: 16'h0000, btn: 32'h0000_0101, chg: 1'b0};
        vt[2] = '{p0: 16'h0000, p1: 16'h0810, btn: 32'h0810_0000, chg: 1'b1};
        vt[3] = '{p0: 16'hFFFF, p1: 16'hFFFF, btn: 32'hFFFF_FFFF, chg: 1'b1};
        vt[4] = '{p0: 16'h0000, p1: 16'h0000, btn: 32'h0000_0000, chg: 1'b1};

        pat_a[0] = vt[0].p0;
        pat_a[1] = vt[0].p1;
        repeat (4) @(negedge clk);
        chk_reset_a("reset");
        rst_a = 1'b0;
        mon_a = 1;
        @(negedge clk);
        chk("strb_after_reset", 64'(ifa.joy_strb), 1);

        for (int i = 0; i < 5; i++) begin
            pat_a[0] = vt[i].p0;
            pat_a[1] = vt[i].p1;
            wait_valid_a(ok);
            chk("vec_buttons", 64'(ifa.buttons), 64'(vt[i].btn));
            chk("vec_changed", 64'(ifa.changed), 64'(vt[i].chg));
            chk("vec_pulses", 64'(nfall_a), 16);
            @(negedge clk);
            chk("valid_one_cycle", 64'(ifa.valid), 0);
            chk("changed_one_cycle", 64'(ifa.changed), 0);
        end

        prev = 32'h0;
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 2) begin
                p0 = prev[15:0];
                p1 = prev[31:16];
            end else begin
                p0 = 16'($urandom);
                p1 = 16'($urandom);
            end
            expv     = {p1, p0};
            pat_a[0] = p0;
            pat_a[1] = p1;
            wait_valid_a(ok);
            chk("rand_buttons", 64'(ifa.buttons), 64'(expv));
            chk("rand_changed", 64'(ifa.changed), 64'(expv != prev));
            prev = expv;
        end

        pat_a[0] = 16'h8001;
        pat_a[1] = 16'h4000;
        wait_valid_a(ok);
        chk("pre_reset_buttons", 64'(ifa.buttons), 64'h4000_8001);

        ok = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (idx_a == 7 && !ifa.joy_clk) begin
                ok = 1;
                break;
            end
        end
        chk("reach_bit7", 64'(ok), 1);
        rst_a = 1'b1;
        @(negedge clk);
        chk_reset_a("midreset");
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        chk("strb_after_midreset", 64'(ifa.joy_strb), 1);
        wait_valid_a(ok);
        chk("post_reset_buttons", 64'(ifa.buttons), 64'h4000_8001);
        chk("post_reset_changed", 64'(ifa.changed), 1);
        chk("post_reset_pulses", 64'(nfall_a), 16);
        repeat (30) @(negedge clk);
    endtask

    task automatic run_b();
        bit         ok;
        logic [7:0] prev;
        logic [7:0] expv;

        pat_b = 8'h08;
        repeat (4) @(negedge clk);
        chk("b_reset_clk", 64'(ifb.joy_clk), 1);
        chk("b_reset_buttons", 64'(ifb.buttons), 0);
        rst_b = 1'b0;
        wait_valid_b(ok);
        chk("b_start_buttons", 64'(ifb.buttons), 64'h08);
        chk("b_start_changed", 64'(ifb.changed), 1);
        chk("b_pulses", 64'(nfall_b), 8);

        prev = 8'h08;
        for (int k = 0; k < 4; k++) begin
            expv  = (k == 1) ? prev : 8'($urandom);
            pat_b = expv;
            wait_valid_b(ok);
            chk("b_rand_buttons", 64'(ifb.buttons), 64'(expv));
            chk("b_rand_changed", 64'(ifb.changed), 64'(expv != prev));
            chk("b_rand_pulses", 64'(nfall_b), 8);
            prev = expv;
        end
    endtask

`ifdef CONTROLLER_SCAN_TRIGGER_EN
    task automatic run_trig();
        bit ok;
        bit seen;

        pat_a[0]     = 16'h0101;
        pat_a[1]     = 16'h0002;
        ifa.scan_req = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_a("reset");
        rst_a = 1'b0;

        seen = 0;
        repeat (3000) begin
            @(negedge clk);
            if (ifa.joy_strb) seen = 1;
        end
        chk("idle_no_strb", 64'(seen), 0);

        ifa.scan_req = 1'b1;
        @(negedge clk);
        ifa.scan_req = 1'b0;
        chk("latch_not_yet", 64'(ifa.joy_strb), 0);
        @(negedge clk);
        chk("latch_next_cycle", 64'(ifa.joy_strb), 1);

        ok = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (!ifa.joy_clk) begin
                ok = 1;
                break;
            end
        end
        chk("reach_clk_low", 64'(ok), 1);
        ifa.scan_req = 1'b1;
        @(negedge clk);
        ifa.scan_req = 1'b0;

        wait_valid_a(ok);
        chk("trig_buttons", 64'(ifa.buttons), 64'h0002_0101);
        chk("trig_changed", 64'(ifa.changed), 1);

        seen = 0;
        repeat (1500) begin
            @(negedge clk);
            if (ifa.joy_strb) seen = 1;
        end
        chk("req_in_clk_low_ignored", 64'(seen), 0);
    endtask
`endif

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
`ifdef CONTROLLER_SCAN_TRIGGER_EN
        run_trig();
`else
        fork
            run_a();
            run_b();
        join
`endif
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
